// File: rtl/xorshift_pkg.sv
// Shared definitions for the xorshift PRNG: FSM encoding, shift triplets,
// output-scrambler multipliers and the zero-seed fix-up.
package xorshift_pkg;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_VALID = 1'b1
   } state_t;

   localparam int SH32_A = 13;
   localparam int SH32_B = 17;
   localparam int SH32_C = 5;

   localparam int SH64_A = 13;
   localparam int SH64_B = 7;
   localparam int SH64_C = 17;

   localparam logic [31:0] MULT32 = 32'h9E37_79BB;
   localparam logic [63:0] MULT64 = 64'h2545_F491_4F6C_DD1D;

   // Zero is a fixed point of xorshift, so it is replaced by 1.
   function automatic logic [63:0] fix_seed(input logic [63:0] i_seed);
      return (i_seed == 64'd0) ? 64'd1 : i_seed;
   endfunction

endpackage

// File: rtl/xorshift_step.sv
// One combinational xorshift step; WIDTH selects the (A,B,C) triplet
// (32 -> 13,17,5; 64 -> 13,7,17). Only 32 and 64 are meaningful.
module xorshift_step
   import xorshift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_x,
   output logic [WIDTH-1:0] o_y
);

   localparam int SH_A = (WIDTH == 64) ? SH64_A : SH32_A;
   localparam int SH_B = (WIDTH == 64) ? SH64_B : SH32_B;
   localparam int SH_C = (WIDTH == 64) ? SH64_C : SH32_C;

   logic [WIDTH-1:0] w_t1;
   logic [WIDTH-1:0] w_t2;

   assign w_t1 = i_x  ^ (i_x  << SH_A);
   assign w_t2 = w_t1 ^ (w_t1 >> SH_B);
   assign o_y  = w_t2 ^ (w_t2 << SH_C);

endmodule

// File: rtl/xorshift_prng.sv
// Xorshift PRNG with a valid/ready output port and a seed-load input.
// Define XORSHIFT_STAR_EN to scramble the output with a multiply (xorshift*).
module xorshift_prng
   import xorshift_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             rand_ready,
   output logic             rand_valid,
   output logic [WIDTH-1:0] rand_out,
   output state_t           o_dbg_state
);

   localparam logic [WIDTH-1:0] SEED_FIX = WIDTH'(fix_seed(64'(SEED_DEFAULT)));

   state_t           r_fsm;
   state_t           w_fsm_nxt;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_out;
   logic             r_valid;
   logic [WIDTH-1:0] w_step;
   logic [WIDTH-1:0] w_out;
   logic [WIDTH-1:0] w_seed_fix;
   logic             w_advance;

   xorshift_step #(.WIDTH(WIDTH)) u_step (
      .i_x (r_x),
      .o_y (w_step)
   );

   assign w_seed_fix = WIDTH'(fix_seed(64'(seed)));

`ifdef XORSHIFT_STAR_EN
   localparam logic [WIDTH-1:0] MULT = (WIDTH == 64) ? WIDTH'(MULT64) : WIDTH'(MULT32);
   assign w_out = w_step * MULT;
`else
   assign w_out = w_step;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_fsm <= ST_FILL;
      else        r_fsm <= w_fsm_nxt;
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      if (seed_load) begin
         w_fsm_nxt = ST_FILL;
      end else begin
         case (r_fsm)
            ST_FILL:  w_fsm_nxt = ST_VALID;
            ST_VALID: w_fsm_nxt = ST_VALID;
            default:  w_fsm_nxt = ST_FILL;
         endcase
      end
   end

   // Handshake: a number is consumed on any rising edge where rand_valid and
   // rand_ready are both 1; rand_out then advances, otherwise it holds.
   // seed_load discards the current number and restarts via FILL.
   always_comb begin
      w_advance = 1'b0;
      if (!seed_load) begin
         case (r_fsm)
            ST_FILL:  w_advance = 1'b1;
            ST_VALID: w_advance = rand_ready;
            default:  w_advance = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x     <= SEED_FIX;
         r_out   <= '0;
         r_valid <= 1'b0;
      end else if (seed_load) begin
         r_x     <= w_seed_fix;
         r_valid <= 1'b0;
      end else if (w_advance) begin
         r_x     <= w_step;
         r_out   <= w_out;
         r_valid <= 1'b1;
      end
   end

   assign rand_valid  = r_valid;
   assign rand_out    = r_out;
   assign o_dbg_state = r_fsm;

endmodule
